// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns PS/2 scan-code set 2 byte sequences into key events. It tracks the
//   E0/F0 prefixes, maps common keys to ASCII, counts new key presses and
//   queues events in a first-word-fall-through FIFO behind a valid/ready
//   handshake.
//
//   Optional build macro: PS2_REPEAT_FILTER_EN. When it is defined,
//   typematic repeats of the held key are not queued.
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-high reset
//   rx_data/valid   received byte and its one-cycle strobe
//   ev_code/ascii/break/ext/valid, ev_ready   head event and its handshake
//   key_count       new key presses, modulo 256
//   held_valid/code current held key, coded as {ext, code}
//   overflow        sticky flag: an event was dropped because the FIFO was full
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] ev_code,
  output logic [7:0] ev_ascii,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] key_count,
  output logic       held_valid,
  output logic [8:0] held_code,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t state, next_state;

  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: to_ascii = 8'h61;  8'h32: to_ascii = 8'h62;  8'h21: to_ascii = 8'h63;
      8'h23: to_ascii = 8'h64;  8'h24: to_ascii = 8'h65;  8'h2B: to_ascii = 8'h66;
      8'h34: to_ascii = 8'h67;  8'h33: to_ascii = 8'h68;  8'h43: to_ascii = 8'h69;
      8'h3B: to_ascii = 8'h6A;  8'h42: to_ascii = 8'h6B;  8'h4B: to_ascii = 8'h6C;
      8'h3A: to_ascii = 8'h6D;  8'h31: to_ascii = 8'h6E;  8'h44: to_ascii = 8'h6F;
      8'h4D: to_ascii = 8'h70;  8'h15: to_ascii = 8'h71;  8'h2D: to_ascii = 8'h72;
      8'h1B: to_ascii = 8'h73;  8'h2C: to_ascii = 8'h74;  8'h3C: to_ascii = 8'h75;
      8'h2A: to_ascii = 8'h76;  8'h1D: to_ascii = 8'h77;  8'h22: to_ascii = 8'h78;
      8'h35: to_ascii = 8'h79;  8'h1A: to_ascii = 8'h7A;
      8'h45: to_ascii = 8'h30;  8'h16: to_ascii = 8'h31;  8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33;  8'h25: to_ascii = 8'h34;  8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36;  8'h3D: to_ascii = 8'h37;  8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;
      8'h29: to_ascii = 8'h20;  8'h5A: to_ascii = 8'h0D;
      default: to_ascii = 8'h00;
    endcase
  endfunction

  // Byte classification
  logic is_ctrl, is_e0, is_f0, complete;
  assign is_ctrl = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                   (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);
  assign is_e0    = (rx_data == 8'hE0);
  assign is_f0    = (rx_data == 8'hF0);
  assign complete = rx_valid && !is_ctrl && !is_e0 && !is_f0;

  // Prefix FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rx_valid) begin
      if (is_ctrl)                  next_state = S_IDLE;
      else if (is_e0) begin
        if (state == S_IDLE)        next_state = S_E0;
        else if (state == S_F0)     next_state = S_E0F0;
      end else if (is_f0) begin
        if (state == S_IDLE)        next_state = S_F0;
        else if (state == S_E0)     next_state = S_E0F0;
      end else                      next_state = S_IDLE;
    end
  end

  // Event being formed this cycle
  logic        in_ext, in_brk, is_repeat, push;
  logic [17:0] in_word;
  assign in_ext    = (state == S_E0) || (state == S_E0F0);
  assign in_brk    = (state == S_F0) || (state == S_E0F0);
  assign is_repeat = held_valid && (held_code == {in_ext, rx_data});
  assign in_word   = {in_ext, in_brk, rx_data, in_ext ? 8'h00 : to_ascii(rx_data)};

`ifdef PS2_REPEAT_FILTER_EN
  assign push = complete && !(!in_brk && is_repeat);
`else
  assign push = complete;
`endif

  // Held key tracking and press counter
  always_ff @(posedge clk) begin
    if (reset) begin
      key_count  <= '0;
      held_valid <= 1'b0;
      held_code  <= '0;
    end else if (complete) begin
      if (!in_brk) begin
        if (!is_repeat) begin
          key_count  <= key_count + 8'd1;
          held_valid <= 1'b1;
          held_code  <= {in_ext, rx_data};
        end
      end else if (is_repeat) begin
        // a break whose {ext, code} matches the held key releases it
        held_valid <= 1'b0;
      end
    end
  end

  // Event FIFO, first-word-fall-through
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  // Head fields are forced to zero while empty so reset and idle read as zero
  logic [17:0] head;
  assign head     = ev_valid ? mem[rd_ptr] : 18'd0;
  assign ev_ext   = head[17];
  assign ev_break = head[16];
  assign ev_code  = head[15:8];
  assign ev_ascii = head[7:0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed byte sequences push expected
// events into a queue; a monitor pops and compares on every handshake.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] ev_code, ev_ascii, key_count;
  logic       ev_break, ev_ext, ev_valid, ev_ready;
  logic       held_valid, overflow;
  logic [8:0] held_code;

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_code(ev_code), .ev_ascii(ev_ascii), .ev_break(ev_break), .ev_ext(ev_ext),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .key_count(key_count),
    .held_valid(held_valid), .held_code(held_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] sb [$];
  bit          sb_off = 1'b0;
  int          pop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ev(input logic [7:0] code, input logic [7:0] asc,
                                     input logic brk, input logic ext);
    return {ext, brk, code, asc};
  endfunction

  // Monitor: a handshake seen at the falling edge is the pop at the next rising edge
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (sb_off) pop_cnt++;
      else if (sb.size() == 0) chk("unexpected_event", {14'd0, ev_ext, ev_break, ev_code, ev_ascii}, 32'hDEAD);
      else chk("event", {14'd0, ev_ext, ev_break, ev_code, ev_ascii}, {14'd0, sb.pop_front()});
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || ev_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk({name, "_drain_timeout"}, sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_fields", {ev_ext, ev_break, ev_code, ev_ascii}, 0);
    chk("rst_key_count", key_count, 0);
    chk("rst_held", {held_valid, held_code}, 0);
    chk("rst_overflow", overflow, 0);

    // press and release 'a'
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("t1");
    chk("t1_key_count", key_count, 1);
    chk("t1_held_valid", held_valid, 0);

    // extended key E0 75
    sb.push_back(ev(8'h75, 8'h00, 0, 1));
    sb.push_back(ev(8'h75, 8'h00, 1, 1));
    send(8'hE0); send(8'h75);
    chk("t2_held", {held_valid, held_code}, {1'b1, 9'h175});
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("t2");
    chk("t2_released", held_valid, 0);
    chk("t2_key_count", key_count, 2);

    // typematic repeats
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
`ifndef PS2_REPEAT_FILTER_EN
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
`endif
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain("t3");
    chk("t3_key_count", key_count, 3);

    // overflow: stalled consumer, five events, four kept
    ev_ready = 1'b0;
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t4_no_overflow_yet", overflow, 0);
    send(8'h1C);
    chk("t4_overflow", overflow, 1);
    chk("t4_head_stable", {ev_valid, ev_break, ev_code}, {1'b1, 1'b0, 8'h1C});
    chk("t4_key_count", key_count, 6);
    chk("t4_held", {held_valid, held_code}, {1'b1, 9'h01C});
    ev_ready = 1'b1;
    drain("t4");
    chk("t4_overflow_sticky", overflow, 1);
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    send(8'hF0); send(8'h1C);
    drain("t4b");
    chk("t4_released", held_valid, 0);

    // control byte cancels a pending F0
    sb.push_back(ev(8'h32, 8'h62, 0, 0));
    send(8'hF0); send(8'hAA); send(8'h32);
    drain("t5");
    chk("t5_held", {held_valid, held_code}, {1'b1, 9'h032});

    // reset one cycle after E0 drops the prefix
    send(8'hE0);
    do_reset();
    chk("t5_rst_valid", ev_valid, 0);
    chk("t5_rst_overflow", overflow, 0);
    chk("t5_rst_key_count", key_count, 0);
    sb.push_back(ev(8'h75, 8'h00, 0, 0));
    send(8'h75);
    drain("t5b");
    chk("t5_held_code", held_code, 9'h075);

    // push and pop together while full: nothing dropped
    ev_ready = 1'b0;
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    sb.push_back(ev(8'h1C, 8'h61, 0, 0));
    sb.push_back(ev(8'h1C, 8'h61, 1, 0));
    sb.push_back(ev(8'h29, 8'h20, 0, 0));
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'hF0); send(8'h1C);
    ev_ready = 1'b1;
    send(8'h29);
    drain("t6");
    chk("t6_no_overflow", overflow, 0);
    chk("t6_key_count", key_count, 4);

    // 256 make/break pairs wrap the counter
    do_reset();
    sb_off = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'h01 + {1'b0, i[6:0]};
      if (i[7]) send(8'hE0);
      send(c);
      if (i[7]) send(8'hE0);
      send(8'hF0); send(c);
      if (i == 254) chk("t7_count_255", key_count, 8'hFF);
    end
    repeat (3) @(posedge clk);
    #1;
    sb_off = 1'b0;
    chk("t7_wrap", key_count, 0);
    chk("t7_held", held_valid, 0);
    chk("t7_events", pop_cnt, 512);
    chk("t7_overflow", overflow, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the raw byte stream from the PS/2 serial receiver and turns scan-code set 2 sequences into key events. Tracks the E0/F0 prefixes, maps common keys to ASCII, counts new key presses and buffers events in a small FIFO behind a valid/ready handshake. It sits directly downstream of the PS/2 receiver and feeds display or console logic.

## Interface
- FIFO_DEPTH, 4, event FIFO depth in entries; power of two, ≥2.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the PS/2 receiver, with start, stop and parity already checked.
- rx_valid  in  1  one-cycle pulse per received byte. Back-to-back pulses are legal.
- ev_code  out  8  scan code of the head event (prefixes stripped).
- ev_ascii  out  8  ASCII value of the head event; 0x00 if the key is unmapped.
- ev_break  out  1  head event is a release (F0 seen).
- ev_ext  out  1  head event is extended (E0 seen).
- ev_valid  out  1  the FIFO is non-empty and the head event is valid.
- ev_ready  in  1  consumer accepts the head event; a pop happens when ev_valid & ev_ready.
- key_count  out  8  number of new key presses, modulo 256.
- held_valid  out  1  a key is currently held.
- held_code  out  9  {ext, code} of the most recent held key.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Prefix FSM. Each byte with rx_valid high moves the FSM:
  - States: IDLE, E0, F0, E0F0.
  - IDLE --E0--> E0
  - IDLE --F0--> F0
  - E0 --F0--> E0F0
  - F0 --E0--> E0F0
  - A repeated prefix keeps the current state.
  - Any other byte completes the sequence and returns the FSM to IDLE.
- Control bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF are discarded in any state. They produce no event and return the FSM to IDLE.
- A completed byte forms an event {code = byte, ext = E0 seen, break = F0 seen}.
- Make event (break = 0):
  - It is a repeat if held_valid is high and held_code == {ext, code}.
  - A non-repeat increments key_count (255 wraps to 0), then sets held_code = {ext, code} and held_valid = 1.
- Break event: if held_valid is high and held_code == {ext, code}, held_valid is cleared. Otherwise held state is unchanged.
- ASCII mapping applies only when ext = 0; it ignores the break flag. All other codes, and every code with ext = 1, give 0x00.
  - Letters (lowercase a..z): 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Other keys: 29 → 0x20, 5A → 0x0D.
- FIFO:
  - Entries are 18 bits: {ext, break, code, ascii}, with first-word-fall-through.
  - A push while the FIFO is full drops the event and sets overflow.
  - If a push and a pop happen in the same cycle while full, both succeed and overflow is not set.
  - A push and a pop in the same cycle while empty is impossible, because the FIFO is first-word-fall-through.

## Timing
- rx_valid at cycle N:
  - FSM, held state and key_count update at edge N+1.
  - The event is written at edge N+1.
  - If the FIFO was empty, ev_valid is high in cycle N+1.
- Pop at edge M: the next entry, or ev_valid = 0, is visible in cycle M+1.
- Outputs stay stable while ev_valid & !ev_ready.
- Reset values:
  - FSM = IDLE.
  - FIFO empty; ev_valid = 0.
  - ev_code, ev_ascii, ev_break and ev_ext = 0.
  - key_count = 0, held_valid = 0, held_code = 0, overflow = 0.
- Reset takes priority over rx_valid and over pop in the same cycle. A sequence that was partially received (a pending prefix) is discarded.

## Configuration
- PS2_REPEAT_FILTER_EN:
  - Defined: make events classed as repeats (typematic) are not pushed to the FIFO.
  - Undefined: every make event is pushed.
- key_count and held state behave the same in both builds.

## Test plan
- Bytes 1C, F0, 1C with an idle consumer: three bytes yield two events, {1C, 'a'=0x61, brk=0, ext=0} then {1C, 0x61, brk=1, ext=0}. key_count = 1 and held_valid = 0 at the end.
- Bytes E0, 75, E0, F0, 75: events {75, 0x00, brk=0, ext=1} then {75, 0x00, brk=1, ext=1}. held_code = 0x175 while the key is held.
- Bytes 1C, 1C, 1C, F0, 1C:
  - Filter defined: 2 events.
  - Filter undefined: 4 events.
  - key_count = 1 in both builds.
- ev_ready held low; then 1C and F0 1C repeated until more than FIFO_DEPTH = 4 events are generated. Exactly 4 events are kept, overflow = 1 stays high, and events drain in order after ev_ready goes high.
- Bytes F0, AA, then 32: AA is discarded and clears F0, so the only event is {32, 'b'=0x62, brk=0}. Separately, reset asserted one cycle after an E0 leaves ev_valid = 0, and a following 75 is decoded with ext = 0.
- 256 distinct make/break pairs: key_count wraps to 0x00.
